// File: rtl/fp_pkg.sv
// Shared floating-point datapath definitions: default field widths, derived
// constants and the status-flag bundle passed between FP adder stages.
package fp_pkg;

    localparam int FP_EXP_WIDTH  = 8;
    localparam int FP_MANT_WIDTH = 23;
    localparam int FP_SW         = $clog2(FP_MANT_WIDTH + 2);
    localparam int FP_EXP_MAX    = (1 << FP_EXP_WIDTH) - 1;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero;
    } fp_flags_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fp_lzc #(
    parameter int WIDTH = 24,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CW-1:0]    count
);

    // Ascending scan so the most significant set bit is the last one to win.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_norm_adjust.sv
// Two-stage normalise and exponent-adjust stage of the FP adder, between the
// significand add/subtract and rounding, with valid/ready on both sides.
module fp_norm_adjust
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH    = FP_EXP_WIDTH,
    parameter int MANT_WIDTH   = FP_MANT_WIDTH,
    parameter bit FLUSH_DENORM = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXP_WIDTH-1:0]  in_exp,
    input  logic [MANT_WIDTH+1:0] in_mant,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic [EXP_WIDTH-1:0]  out_exp,
    output logic [MANT_WIDTH:0]   out_mant,
    output logic                  out_sticky,
    output logic                  out_ovf,
    output logic                  out_unf,
    output logic                  out_zero
);

    localparam int SW = $clog2(MANT_WIDTH + 2);
    // Wide enough for exp+1 without wrap and for any lzc value.
    localparam int XW = (EXP_WIDTH + 1 > SW) ? EXP_WIDTH + 1 : SW + 1;
    localparam logic [XW-1:0] EXP_MAX_X = XW'({EXP_WIDTH{1'b1}});

    logic                  s1_valid;
    logic                  s1_sign;
    logic [EXP_WIDTH-1:0]  s1_exp;
    logic [MANT_WIDTH+1:0] s1_mant;
    logic [SW-1:0]         s1_lzc;
    logic [SW-1:0]         in_lzc;

    logic                  s2_valid;
    logic                  s1_adv;
    logic                  s2_adv;
    fp_flags_t             out_flags;

    logic [XW-1:0]         exp_x;
    logic [XW-1:0]         lzc_x;
    logic [XW-1:0]         exp_inc;
    logic [XW-1:0]         exp_sub;
    logic [XW-1:0]         denorm_shift;
    logic [EXP_WIDTH-1:0]  nx_exp;
    logic [MANT_WIDTH:0]   nx_mant;
    logic                  nx_sticky;
    fp_flags_t             nx_flags;

    fp_lzc #(
        .WIDTH(MANT_WIDTH + 1),
        .CW   (SW)
    ) u_lzc (
        .data (in_mant[MANT_WIDTH:0]),
        .count(in_lzc)
    );

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    assign out_valid = s2_valid;
    assign out_ovf   = out_flags.ovf;
    assign out_unf   = out_flags.unf;
    assign out_zero  = out_flags.zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_lzc   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_exp  <= in_exp;
                s1_mant <= in_mant;
                s1_lzc  <= in_lzc;
            end
        end
    end

    assign exp_x        = XW'(s1_exp);
    assign lzc_x        = XW'(s1_lzc);
    assign exp_inc      = exp_x + XW'(1);
    assign exp_sub      = exp_x - lzc_x;
    assign denorm_shift = (exp_x == '0) ? '0 : exp_x - XW'(1);

    // Case priority: carry-out, exact zero, normal left shift, underflow.
    always_comb begin
        nx_exp    = '0;
        nx_mant   = '0;
        nx_sticky = 1'b0;
        nx_flags  = '0;
        if (s1_mant[MANT_WIDTH+1]) begin
            nx_sticky = s1_mant[0];
            if (exp_inc >= EXP_MAX_X) begin
                nx_exp       = '1;
                nx_flags.ovf = 1'b1;
            end else begin
                nx_exp  = exp_inc[EXP_WIDTH-1:0];
                nx_mant = s1_mant[MANT_WIDTH+1:1];
            end
        end else if (s1_mant == '0) begin
            nx_flags.zero = 1'b1;
        end else if (exp_x > lzc_x) begin
            nx_exp  = exp_sub[EXP_WIDTH-1:0];
            nx_mant = s1_mant[MANT_WIDTH:0] << s1_lzc;
        end else begin
            nx_flags.unf = 1'b1;
            if (FLUSH_DENORM) begin
                nx_flags.zero = 1'b1;
            end else begin
                nx_mant = s1_mant[MANT_WIDTH:0] << denorm_shift;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_sign   <= 1'b0;
            out_exp    <= '0;
            out_mant   <= '0;
            out_sticky <= 1'b0;
            out_flags  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sign   <= s1_sign;
                out_exp    <= nx_exp;
                out_mant   <= nx_mant;
                out_sticky <= nx_sticky;
                out_flags  <= nx_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_adjust.sv
// Directed bench for fp_norm_adjust: vector table on flush and denormal
// instances, then backpressure and mid-stream reset sequences.
module tb_fp_norm_adjust;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_ready;

    logic        in_ready, out_valid, out_sign, out_sticky, out_ovf, out_unf, out_zero;
    logic [7:0]  out_exp;
    logic [23:0] out_mant;

    logic        dn_in_ready, dn_out_valid, dn_out_sign, dn_out_sticky, dn_out_ovf, dn_out_unf, dn_out_zero;
    logic [7:0]  dn_out_exp;
    logic [23:0] dn_out_mant;

    int n_compared;
    int n_mismatched;

    logic        cap_valid, cap_ready, cap_sign, cap_sticky, cap_ovf, cap_unf, cap_zero;
    logic [7:0]  cap_exp, cap_dn_exp;
    logic [23:0] cap_mant, cap_dn_mant;
    logic        cap_dn_unf, cap_dn_zero;

    fp_norm_adjust #(.EXP_WIDTH(8), .MANT_WIDTH(23), .FLUSH_DENORM(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
        .out_exp(out_exp), .out_mant(out_mant), .out_sticky(out_sticky),
        .out_ovf(out_ovf), .out_unf(out_unf), .out_zero(out_zero)
    );

    fp_norm_adjust #(.EXP_WIDTH(8), .MANT_WIDTH(23), .FLUSH_DENORM(1'b0)) dut_dn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dn_in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(dn_out_valid), .out_ready(out_ready), .out_sign(dn_out_sign),
        .out_exp(dn_out_exp), .out_mant(dn_out_mant), .out_sticky(dn_out_sticky),
        .out_ovf(dn_out_ovf), .out_unf(dn_out_unf), .out_zero(dn_out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  e;
        logic [24:0] m;
        logic [7:0]  x_exp;
        logic [23:0] x_mant;
        logic        x_sticky;
        logic        x_ovf;
        logic        x_unf;
        logic        x_zero;
        logic [23:0] x_dn_mant;
        logic        x_dn_zero;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One clock cycle: drive inputs just after an edge, sample mid-cycle, step past the next edge.
    task automatic applyStimulus(input logic v, input logic [7:0] e, input logic [24:0] m,
                                 output logic acc, output logic got);
        in_valid = v;
        in_exp   = e;
        in_mant  = m;
        in_sign  = e[0];
        #4;
        acc         = v && in_ready;
        got         = out_valid && out_ready;
        cap_valid   = out_valid;
        cap_ready   = in_ready;
        cap_sign    = out_sign;
        cap_exp     = out_exp;
        cap_mant    = out_mant;
        cap_sticky  = out_sticky;
        cap_ovf     = out_ovf;
        cap_unf     = out_unf;
        cap_zero    = out_zero;
        cap_dn_exp  = dn_out_exp;
        cap_dn_mant = dn_out_mant;
        cap_dn_unf  = dn_out_unf;
        cap_dn_zero = dn_out_zero;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc, got;
        int   sent, recv, recv_cycle, n_recv;
        logic [7:0] recv_exp;

        n_compared   = 0;
        n_mismatched = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b1;

        vecs[0]  = '{8'd127, 25'h1000001, 8'd128, 24'h800000, 1'b1, 1'b0, 1'b0, 1'b0, 24'h800000, 1'b0};
        vecs[1]  = '{8'd127, 25'h0000001, 8'd104, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 24'h800000, 1'b0};
        vecs[2]  = '{8'd127, 25'h0000000, 8'd0,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b1};
        vecs[3]  = '{8'd254, 25'h1800000, 8'd255, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0};
        vecs[4]  = '{8'd5,   25'h0000100, 8'd0,   24'h000000, 1'b0, 1'b0, 1'b1, 1'b1, 24'h001000, 1'b0};
        vecs[5]  = '{8'd255, 25'h1000000, 8'd255, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0};
        vecs[6]  = '{8'd127, 25'h0800000, 8'd127, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 24'h800000, 1'b0};
        vecs[7]  = '{8'd1,   25'h0800000, 8'd1,   24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 24'h800000, 1'b0};
        vecs[8]  = '{8'd0,   25'h0800000, 8'd0,   24'h000000, 1'b0, 1'b0, 1'b1, 1'b1, 24'h800000, 1'b0};
        vecs[9]  = '{8'd24,  25'h0000001, 8'd1,   24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 24'h800000, 1'b0};
        vecs[10] = '{8'd23,  25'h0000001, 8'd0,   24'h000000, 1'b0, 1'b0, 1'b1, 1'b1, 24'h400000, 1'b0};
        vecs[11] = '{8'd253, 25'h1FFFFFF, 8'd254, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0};
        vecs[12] = '{8'd100, 25'h0400001, 8'd99,  24'h800002, 1'b0, 1'b0, 1'b0, 1'b0, 24'h800002, 1'b0};
        vecs[13] = '{8'd0,   25'h1000000, 8'd1,   24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 24'h800000, 1'b0};

        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_exp", out_exp, 0);
        checkOutput("reset_out_mant", out_mant, 0);
        checkOutput("reset_flags", {out_sign, out_sticky, out_ovf, out_unf, out_zero}, 0);

        // Each vector goes into an empty pipe and must appear in the third sampled cycle.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, vecs[i].e, vecs[i].m, acc, got);
            checkOutput($sformatf("v%0d_accept", i), acc, 1);
            applyStimulus(1'b0, 8'd0, 25'd0, acc, got);
            checkOutput($sformatf("v%0d_early_valid", i), cap_valid, 0);
            applyStimulus(1'b0, 8'd0, 25'd0, acc, got);
            checkOutput($sformatf("v%0d_valid", i), cap_valid, 1);
            checkOutput($sformatf("v%0d_sign", i), cap_sign, vecs[i].e[0]);
            checkOutput($sformatf("v%0d_exp", i), cap_exp, vecs[i].x_exp);
            checkOutput($sformatf("v%0d_mant", i), cap_mant, vecs[i].x_mant);
            checkOutput($sformatf("v%0d_sticky", i), cap_sticky, vecs[i].x_sticky);
            checkOutput($sformatf("v%0d_ovf", i), cap_ovf, vecs[i].x_ovf);
            checkOutput($sformatf("v%0d_unf", i), cap_unf, vecs[i].x_unf);
            checkOutput($sformatf("v%0d_zero", i), cap_zero, vecs[i].x_zero);
            checkOutput($sformatf("v%0d_dn_exp", i), cap_dn_exp, vecs[i].x_exp);
            checkOutput($sformatf("v%0d_dn_mant", i), cap_dn_mant, vecs[i].x_dn_mant);
            checkOutput($sformatf("v%0d_dn_unf", i), cap_dn_unf, vecs[i].x_unf);
            checkOutput($sformatf("v%0d_dn_zero", i), cap_dn_zero, vecs[i].x_dn_zero);
        end
        applyStimulus(1'b0, 8'd0, 25'd0, acc, got);
        checkOutput("table_drained", cap_valid, 0);

        // Backpressure: out_ready low for cycles 1-4, four beats offered back to back.
        $display("[TB] backpressure sequence");
        out_ready = 1'b0;
        sent = 0;
        recv = 0;
        for (int c = 1; c <= 24 && recv < 4; c++) begin
            if (c == 5) out_ready = 1'b1;
            applyStimulus(sent < 4, 8'(100 + sent), 25'h0800000 | 25'(sent), acc, got);
            if (c == 3 || c == 4) begin
                checkOutput("bp_accepted_before_stall", sent, 2);
                checkOutput("bp_in_ready_low", cap_ready, 0);
                checkOutput("bp_hold_valid", cap_valid, 1);
                checkOutput("bp_hold_exp", cap_exp, 100);
                checkOutput("bp_hold_mant", cap_mant, 24'h800000);
            end
            if (acc) sent++;
            if (got) begin
                checkOutput("bp_order_exp", cap_exp, 100 + recv);
                checkOutput("bp_order_mant", cap_mant, 24'h800000 | 24'(recv));
                recv++;
            end
        end
        checkOutput("bp_received_count", recv, 4);
        applyStimulus(1'b0, 8'd0, 25'd0, acc, got);
        applyStimulus(1'b0, 8'd0, 25'd0, acc, got);
        checkOutput("bp_no_duplicate", cap_valid, 0);

        // Mid-stream reset with both stages occupied and a beat offered in the reset cycle.
        $display("[TB] mid-stream reset sequence");
        out_ready = 1'b0;
        applyStimulus(1'b1, 8'd60, 25'h0800000, acc, got);
        applyStimulus(1'b1, 8'd61, 25'h0800000, acc, got);
        checkOutput("rst_pipe_full", in_ready, 0);
        rst = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b1, 8'd62, 25'h0800000, acc, got);
        rst = 1'b0;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_exp", out_exp, 0);
        checkOutput("rst_out_mant", out_mant, 0);
        n_recv = 0;
        recv_cycle = 0;
        recv_exp = '0;
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(k == 1, 8'd70, 25'h0800000, acc, got);
            if (got) begin
                n_recv++;
                recv_cycle = k;
                recv_exp = cap_exp;
            end
        end
        checkOutput("rst_new_beat_count", n_recv, 1);
        checkOutput("rst_new_beat_exp", recv_exp, 70);
        checkOutput("rst_new_beat_latency", recv_cycle, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
